vga_timing_gen: RTL and testbench

- Raster timing source for the VGA path. Produces the pixel coordinates (`current_row` = horizontal pixel, `current_line` = vertical line), the active-video `enable` and the `hsync`/`vsync` pulses.
- Its coordinate and enable outputs feed the pixel-colour driver. Its sync outputs go to the connector, delayed to line up with the driver's registered colour output.
- Default mode is 640x480 at 60 Hz, from `clk_in` divided down to the pixel rate by an internal clock-enable.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/pixel_tick_div.sv | 29 ++
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the 640x480@60 VGA path: timing, the colour
// driver's cell grid and the default sync polarity.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CELL_ROW_PERIOD  = 48;
  localparam int CELL_LINE_PERIOD = 64;

  localparam logic SYNC_POL_DEF = 1'b0;

  // Inclusive window test on full-width counts; never wraps.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] last);
    return (cnt >= first) && (cnt <= last);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides clk_in down to the pixel rate as a one-cycle clock-enable.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic reset,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q >= DIV_LAST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  assign tick = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, active-video enable, and sync
// pulses delayed to align with the colour driver's registered output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV    = 4,
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic SYNC_POL   = SYNC_POL_DEF,
  parameter int   SYNC_DELAY = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  output logic [CNT_W-1:0] current_row,
  output logic [CNT_W-1:0] current_line,
  output logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             tick;
  logic [CNT_W-1:0] row_q, line_q;
  logic [CNT_W-1:0] row_d, line_d;
  logic             enable_q, pix_tick_q, line_start_q, frame_start_q;
  logic             hsync_raw_q, vsync_raw_q;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk_in (clk_in),
    .reset  (reset),
    .tick   (tick)
  );

  // Out-of-range counts (e.g. upset) take the wrap path and clear to 0.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    row_d  = row_q + 1'b1;
    line_d = line_q;
    if (row_q >= H_LAST) begin
      row_d  = '0;
      line_d = (line_q >= V_LAST) ? '0 : line_q + 1'b1;
    end else if (line_q > V_LAST) begin
      line_d = '0;
    end
  end

  // Enable and raw syncs decode the next coordinates so they load in the
  // same register stage as the counters and are never skewed from them.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      row_q         <= '0;
      line_q        <= '0;
      enable_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_raw_q   <= ~SYNC_POL;
      vsync_raw_q   <= ~SYNC_POL;
    end else begin
      pix_tick_q    <= tick;
      line_start_q  <= tick && (row_d == '0);
      frame_start_q <= tick && (row_d == '0) && (line_d == '0);
      if (tick) begin
        row_q       <= row_d;
        line_q      <= line_d;
        enable_q    <= (row_d < H_ACT) && (line_d < V_ACT);
        hsync_raw_q <= in_window(row_d, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_raw_q <= in_window(line_d, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_dly
      assign hsync = hsync_raw_q;
      assign vsync = vsync_raw_q;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hs_dly_q, vs_dly_q;

      // NOTE: the delay stages are reset to the idle level so the connector
      // never sees a spurious sync pulse while the pipe refills.
      always_ff @(posedge clk_in) begin
        if (reset) begin
          hs_dly_q <= {SYNC_DELAY{~SYNC_POL}};
          vs_dly_q <= {SYNC_DELAY{~SYNC_POL}};
        end else begin
          hs_dly_q <= SYNC_DELAY'({hs_dly_q, hsync_raw_q});
          vs_dly_q <= SYNC_DELAY'({vs_dly_q, vsync_raw_q});
        end
      end

      assign hsync = hs_dly_q[SYNC_DELAY-1];
      assign vsync = vs_dly_q[SYNC_DELAY-1];
    end
  endgenerate

  assign current_row  = row_q;
  assign current_line = line_q;
  assign enable       = enable_q;
  assign pix_tick     = pix_tick_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven from one reset,
// compared against fixed vectors and a tick-count based reference model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] line;
    logic       en;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       ls;
    logic       fs;
  } outs_t;

  typedef struct {
    int   cd, sd;
    int   ha, hf, hs, hb;
    int   va, vf, vs, vb;
    logic pol;
  } cfg_t;

  typedef struct {
    int    inst;
    int    n;
    outs_t exp;
  } vec_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [9:0] row_w [3];
  logic [9:0] line_w[3];
  logic       en_w[3], hs_w[3], vs_w[3], pt_w[3], ls_w[3], fs_w[3];
  outs_t      dut_o[3];

  cfg_t  cfg[3];
  string inst_name[3] = '{"def", "div1", "small"};

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;   // clk_in edges since reset was released

  // Default timing, CLK_DIV=4, SYNC_DELAY=1, active-low syncs.
  vga_timing_gen u_def (
    .clk_in(clk_in), .reset(reset),
    .current_row(row_w[0]), .current_line(line_w[0]), .enable(en_w[0]),
    .hsync(hs_w[0]), .vsync(vs_w[0]), .pix_tick(pt_w[0]),
    .line_start(ls_w[0]), .frame_start(fs_w[0])
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_DELAY(0)) u_div1 (
    .clk_in(clk_in), .reset(reset),
    .current_row(row_w[1]), .current_line(line_w[1]), .enable(en_w[1]),
    .hsync(hs_w[1]), .vsync(vs_w[1]), .pix_tick(pt_w[1]),
    .line_start(ls_w[1]), .frame_start(fs_w[1])
  );

  // Shrunken raster so whole frames and vsync fit in a short run.
  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .SYNC_DELAY(2)
  ) u_small (
    .clk_in(clk_in), .reset(reset),
    .current_row(row_w[2]), .current_line(line_w[2]), .enable(en_w[2]),
    .hsync(hs_w[2]), .vsync(vs_w[2]), .pix_tick(pt_w[2]),
    .line_start(ls_w[2]), .frame_start(fs_w[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++)
      dut_o[i] = {row_w[i], line_w[i], en_w[i], hs_w[i], vs_w[i], pt_w[i], ls_w[i], fs_w[i]};
  end

  // Expected outputs after n edges, from tick count t = n / CLK_DIV:
  // row = t mod H_TOTAL, line = (t div H_TOTAL) mod V_TOTAL; syncs use the
  // tick count SYNC_DELAY edges earlier.
  function automatic outs_t model(input int n_i, input cfg_t c);
    outs_t o;
    int ht, vt, t, r, l, ns, ts, sr, sl;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    t  = n_i / c.cd;
    r  = t % ht;
    l  = (t / ht) % vt;
    o.row  = 10'(r);
    o.line = 10'(l);
    o.pt   = (n_i > 0) && (n_i % c.cd == 0);
    o.en   = (t > 0) && (r < c.ha) && (l < c.va);
    o.ls   = o.pt && (r == 0);
    o.fs   = o.ls && (l == 0);
    ns = n_i - c.sd;
    ts = (ns > 0) ? ns / c.cd : 0;
    sr = ts % ht;
    sl = (ts / ht) % vt;
    o.hs = (sr >= c.ha + c.hf && sr < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
    o.vs = (sl >= c.va + c.vf && sl < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
    return o;
  endfunction

  function automatic outs_t rst_outs(input logic pol);
    outs_t o;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    return o;
  endfunction

  function automatic vec_t mk(input int inst, input int nn, input int row, input int line,
                              input logic en, input logic hs, input logic pt, input logic ls);
    vec_t v;
    v.inst     = inst;
    v.n        = nn;
    v.exp.row  = 10'(row);
    v.exp.line = 10'(line);
    v.exp.en   = en;
    v.exp.hs   = hs;
    v.exp.vs   = 1'b1;
    v.exp.pt   = pt;
    v.exp.ls   = ls;
    v.exp.fs   = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  // One clk_in cycle: drive reset, take the edge, then compare every
  // instance against the model away from the edge.
  task automatic step(input logic r);
    reset = r;
    @(posedge clk_in);
    n = r ? 0 : n + 1;
    @(negedge clk_in);
    for (int i = 0; i < 3; i++)
      check({"model_", inst_name[i]}, 32'(dut_o[i]), 32'(model(n, cfg[i])));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   def_pt, def_ls, def_hs_low, d1_pt, d1_ls, d1_hs_low, guard, cnt;

    cfg[0] = '{cd:4, sd:1, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:1'b0};
    cfg[1] = '{cd:1, sd:0, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:1'b0};
    cfg[2] = '{cd:3, sd:2, ha:10,  hf:2,  hs:3,  hb:2,  va:6,   vf:1,  vs:2, vb:2,  pol:1'b1};

    //                inst  n     row  line en  hs  pt  ls
    vecs.push_back(mk(0,    0,    0,   0,   0,  1,  0,  0));
    vecs.push_back(mk(0,    3,    0,   0,   0,  1,  0,  0));
    vecs.push_back(mk(0,    4,    1,   0,   1,  1,  1,  0));
    vecs.push_back(mk(0,    5,    1,   0,   1,  1,  0,  0));
    vecs.push_back(mk(0,    2556, 639, 0,   1,  1,  1,  0));
    vecs.push_back(mk(0,    2560, 640, 0,   0,  1,  1,  0));
    vecs.push_back(mk(0,    2624, 656, 0,   0,  1,  1,  0));
    vecs.push_back(mk(0,    2625, 656, 0,   0,  0,  0,  0));
    vecs.push_back(mk(0,    3008, 752, 0,   0,  0,  1,  0));
    vecs.push_back(mk(0,    3009, 752, 0,   0,  1,  0,  0));
    vecs.push_back(mk(0,    3199, 799, 0,   0,  1,  0,  0));
    vecs.push_back(mk(0,    3200, 0,   1,   1,  1,  1,  1));
    vecs.push_back(mk(0,    3201, 0,   1,   1,  1,  0,  0));
    vecs.push_back(mk(1,    0,    0,   0,   0,  1,  0,  0));
    vecs.push_back(mk(1,    1,    1,   0,   1,  1,  1,  0));
    vecs.push_back(mk(1,    639,  639, 0,   1,  1,  1,  0));
    vecs.push_back(mk(1,    640,  640, 0,   0,  1,  1,  0));
    vecs.push_back(mk(1,    655,  655, 0,   0,  1,  1,  0));
    vecs.push_back(mk(1,    656,  656, 0,   0,  0,  1,  0));
    vecs.push_back(mk(1,    751,  751, 0,   0,  0,  1,  0));
    vecs.push_back(mk(1,    752,  752, 0,   0,  1,  1,  0));
    vecs.push_back(mk(1,    799,  799, 0,   0,  1,  1,  0));
    vecs.push_back(mk(1,    800,  0,   1,   1,  1,  1,  1));
    vecs.push_back(mk(1,    801,  1,   1,   1,  1,  1,  0));

    repeat (3) step(1'b1);

    // Vector table plus one-line cadence counts.
    def_pt = 0; def_ls = 0; def_hs_low = 0; d1_pt = 0; d1_ls = 0; d1_hs_low = 0;
    for (int c = 0; c <= 3210; c++) begin
      if (c != 0) step(1'b0);
      foreach (vecs[k])
        if (vecs[k].n == n)
          check($sformatf("vec%0d_%s_n%0d", k, inst_name[vecs[k].inst], n),
                32'(dut_o[vecs[k].inst]), 32'(vecs[k].exp));
      if (n >= 1 && n <= 3200) begin
        def_pt     += int'(pt_w[0]);
        def_ls     += int'(ls_w[0]);
        def_hs_low += int'(!hs_w[0]);
      end
      if (n >= 1 && n <= 800) begin
        d1_pt     += int'(pt_w[1]);
        d1_ls     += int'(ls_w[1]);
        d1_hs_low += int'(!hs_w[1]);
      end
    end
    check("def_tick_count",   def_pt,     800);
    check("def_line_starts",  def_ls,     1);
    check("def_hsync_low",    def_hs_low, 384);
    check("div1_tick_count",  d1_pt,      800);
    check("div1_line_starts", d1_ls,      1);
    check("div1_hsync_low",   d1_hs_low,  96);

    // Reset in the middle of a line, then power-up timing again.
    guard = 0;
    while (row_w[0] != 10'd700 && guard < 4000) begin
      step(1'b0);
      guard++;
    end
    check("reach_row700", 32'(row_w[0]), 700);
    step(1'b1);
    check("rst_mid_def",   32'(dut_o[0]), 32'(rst_outs(1'b0)));
    check("rst_mid_small", 32'(dut_o[2]), 32'(rst_outs(1'b1)));
    guard = 0;
    do begin
      step(1'b0);
      guard++;
    end while (!pt_w[0] && guard < 10);
    check("first_tick_latency", n, 4);
    check("first_tick_row", 32'(row_w[0]), 1);
    guard = 0;
    while (hs_w[0] && guard < 3000) begin
      step(1'b0);
      guard++;
    end
    check("first_hsync_fall", n, 2625);

    // Reset inside the small raster's vsync window.
    guard = 0;
    while (!(row_w[2] == 10'd12 && line_w[2] == 10'd7) && guard < 1200) begin
      step(1'b0);
      guard++;
    end
    check("reach_small_12_7", 32'({row_w[2], line_w[2]}), 32'({10'd12, 10'd7}));
    check("small_vsync_on", 32'(vs_w[2]), 1);
    step(1'b1);
    check("rst_vsync_small", 32'(dut_o[2]), 32'(rst_outs(1'b1)));

    // Frame length of the small raster: 17 x 11 ticks between frame starts.
    guard = 0;
    do begin
      step(1'b0);
      guard++;
    end while (!fs_w[2] && guard < 800);
    check("small_fs_seen", 32'({fs_w[2], ls_w[2]}), 32'(2'b11));
    cnt = 0;
    guard = 0;
    do begin
      step(1'b0);
      cnt += int'(pt_w[2]);
      guard++;
    end while (!fs_w[2] && guard < 800);
    check("small_frame_ticks", cnt, 187);

    // Random reset placement and run lengths, model-checked every cycle.
    for (int s = 0; s < 10; s++) begin
      int hold, run;
      hold = int'($urandom_range(1, 3));
      run  = int'($urandom_range(20, 1200));
      repeat (hold) step(1'b1);
      repeat (run) step(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
